// File: rtl/sbox_share_ctrl.sv
// Shared AES S-box bank sequencer. Arbitrates round-robin between the round datapath
// (128-bit SubBytes) and the key schedule (32-bit SubWord) and substitutes N_SBOX bytes
// per cycle through a single bank of byte-wide S-boxes.
module sbox_share_ctrl #(
  parameter int unsigned N_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rnd_req,
  input  logic [127:0] rnd_data,
  output logic         rnd_gnt,
  output logic         rnd_done,
  output logic [127:0] rnd_result,
  input  logic         key_req,
  input  logic [31:0]  key_data,
  output logic         key_gnt,
  output logic         key_done,
  output logic [31:0]  key_result,
  output logic         busy
);

  if (!(N_SBOX == 1 || N_SBOX == 2 || N_SBOX == 4)) begin : gen_bad_n_sbox
    $error("sbox_share_ctrl: N_SBOX must be 1, 2 or 4");
  end

  localparam int unsigned CntW = 5;
  localparam logic [CntW-1:0] RndLast = CntW'(16 / N_SBOX - 1);
  localparam logic [CntW-1:0] KeyLast = CntW'(4 / N_SBOX - 1);
  // Key word lives in work bytes 12..15, i.e. starts at this chunk.
  localparam logic [CntW-1:0] KeyBase = CntW'(12 / N_SBOX);
  localparam logic OwnerRnd = 1'b0;
  localparam logic OwnerKey = 1'b1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;
  logic [7:0]      work_q [16];
  logic [7:0]      work_d [16];
  logic [127:0]    rnd_res_q, rnd_res_d;
  logic [31:0]     key_res_q, key_res_d;
  logic            rnd_done_q, rnd_done_d;
  logic            key_done_q, key_done_d;

  logic [CntW-1:0] chunk;
  logic [3:0]      sb_idx [N_SBOX];
  logic [7:0]      sb_out [N_SBOX];
  logic [127:0]    load_vec;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // AES S-box: multiplicative inverse (x^254, 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int i = 2; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // S-box bank: select the current chunk's bytes and substitute them.
  always_comb begin
    chunk = cnt_q + ((owner_q == OwnerKey) ? KeyBase : '0);
    for (int j = 0; j < N_SBOX; j++) begin
      sb_idx[j] = 4'(chunk * CntW'(N_SBOX) + CntW'(j));
      sb_out[j] = sbox(work_q[sb_idx[j]]);
    end
  end

  // Arbitration, FSM next state, work register update and result capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_d     = last_q;
    work_d     = work_q;
    rnd_res_d  = rnd_res_q;
    key_res_d  = key_res_q;
    rnd_done_d = 1'b0;
    key_done_d = 1'b0;
    rnd_gnt    = 1'b0;
    key_gnt    = 1'b0;
    load_vec   = key_req ? {96'b0, key_data} : rnd_data;

    unique case (state_q)
      StIdle: begin
        if (rst_n) begin
          // Key wins a tie only when the round datapath was served last.
          if (key_req && (!rnd_req || last_q == OwnerRnd)) begin
            key_gnt = 1'b1;
          end else if (rnd_req) begin
            rnd_gnt = 1'b1;
          end
        end
        if (rnd_gnt || key_gnt) begin
          load_vec = key_gnt ? {96'b0, key_data} : rnd_data;
          state_d  = StRun;
          cnt_d    = '0;
          owner_d  = key_gnt;
          last_d   = key_gnt;
          for (int b = 0; b < 16; b++) begin
            work_d[b] = load_vec[127-8*b -: 8];
          end
        end
      end
      StRun: begin
        for (int j = 0; j < N_SBOX; j++) begin
          work_d[sb_idx[j]] = sb_out[j];
        end
        cnt_d = cnt_q + 1'b1;
        // Results and done are registered on the final chunk so they are valid in DONE.
        if (cnt_q == ((owner_q == OwnerKey) ? KeyLast : RndLast)) begin
          state_d = StDone;
          if (owner_q == OwnerKey) begin
            key_done_d = 1'b1;
            for (int i = 0; i < 4; i++) begin
              key_res_d[31-8*i -: 8] = work_d[12+i];
            end
          end else begin
            rnd_done_d = 1'b1;
            for (int b = 0; b < 16; b++) begin
              rnd_res_d[127-8*b -: 8] = work_d[b];
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      owner_q    <= OwnerRnd;
      last_q     <= OwnerRnd;
      rnd_res_q  <= '0;
      key_res_q  <= '0;
      rnd_done_q <= 1'b0;
      key_done_q <= 1'b0;
      for (int b = 0; b < 16; b++) begin
        work_q[b] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      rnd_res_q  <= rnd_res_d;
      key_res_q  <= key_res_d;
      rnd_done_q <= rnd_done_d;
      key_done_q <= key_done_d;
      for (int b = 0; b < 16; b++) begin
        work_q[b] <= work_d[b];
      end
    end
  end

  assign rnd_done   = rnd_done_q;
  assign key_done   = key_done_q;
  assign rnd_result = rnd_res_q;
  assign key_result = key_res_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl: a table of single jobs with hand-computed S-box
// results, plus sequences for arbitration, mid-job reset and cancelled requests.
module tb_sbox_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n4, rst_n1, sel1;
  logic         rnd_req, key_req;
  logic [127:0] rnd_data;
  logic [31:0]  key_data;

  logic         d4_rnd_gnt, d4_rnd_done, d4_key_gnt, d4_key_done, d4_busy;
  logic [127:0] d4_rnd_result;
  logic [31:0]  d4_key_result;
  logic         d1_rnd_gnt, d1_rnd_done, d1_key_gnt, d1_key_done, d1_busy;
  logic [127:0] d1_rnd_result;
  logic [31:0]  d1_key_result;

  logic         o_rnd_gnt, o_rnd_done, o_key_gnt, o_key_done, o_busy;
  logic [127:0] o_rnd_result;
  logic [31:0]  o_key_result;

  sbox_share_ctrl #(.N_SBOX(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n4),
    .rnd_req(rnd_req), .rnd_data(rnd_data), .rnd_gnt(d4_rnd_gnt), .rnd_done(d4_rnd_done),
    .rnd_result(d4_rnd_result),
    .key_req(key_req), .key_data(key_data), .key_gnt(d4_key_gnt), .key_done(d4_key_done),
    .key_result(d4_key_result), .busy(d4_busy)
  );

  sbox_share_ctrl #(.N_SBOX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n1),
    .rnd_req(rnd_req), .rnd_data(rnd_data), .rnd_gnt(d1_rnd_gnt), .rnd_done(d1_rnd_done),
    .rnd_result(d1_rnd_result),
    .key_req(key_req), .key_data(key_data), .key_gnt(d1_key_gnt), .key_done(d1_key_done),
    .key_result(d1_key_result), .busy(d1_busy)
  );

  // Observe whichever instance is out of reset.
  assign o_rnd_gnt    = sel1 ? d1_rnd_gnt    : d4_rnd_gnt;
  assign o_rnd_done   = sel1 ? d1_rnd_done   : d4_rnd_done;
  assign o_rnd_result = sel1 ? d1_rnd_result : d4_rnd_result;
  assign o_key_gnt    = sel1 ? d1_key_gnt    : d4_key_gnt;
  assign o_key_done   = sel1 ? d1_key_done   : d4_key_done;
  assign o_key_result = sel1 ? d1_key_result : d4_key_result;
  assign o_busy       = sel1 ? d1_busy       : d4_busy;

  typedef struct {
    bit           is_key;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] VRnd    = 128'h193DE3BE_00000000_00000000_000000FF;
  localparam logic [127:0] VRndExp = 128'hD42711AE_63636363_63636363_63636316;

  vec_t         vecs [6];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] exp_rnd;
  logic [31:0]  exp_key;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset(input bit use1);
    rst_n4  = 1'b0;
    rst_n1  = 1'b0;
    rnd_req = 1'b0;
    key_req = 1'b0;
    sel1    = use1;
    repeat (3) @(posedge clk);
    #1;
    if (use1) rst_n1 = 1'b1;
    else rst_n4 = 1'b1;
    exp_rnd = '0;
    exp_key = '0;
  endtask

  // One job on an idle DUT: grant in T, done exactly at T+L+1, busy T+1..T+L+1.
  task automatic run_job(input bit is_key, input logic [127:0] data, input logic [127:0] exp,
                         input string name);
    int n, lat, wait_c, done_at;
    bit busy_ok;
    n   = sel1 ? 1 : 4;
    lat = is_key ? 4 / n : 16 / n;
    @(posedge clk); #1;
    if (is_key) begin
      key_req = 1'b1;
      key_data = data[31:0];
    end else begin
      rnd_req = 1'b1;
      rnd_data = data;
    end
    #1;
    wait_c = 0;
    while (!(is_key ? o_key_gnt : o_rnd_gnt) && wait_c < 10) begin
      @(posedge clk); #2;
      wait_c++;
    end
    check({name, " gnt wait"}, 128'(wait_c), 128'd0);
    check({name, " other gnt"}, 128'(is_key ? o_rnd_gnt : o_key_gnt), 128'd0);
    @(posedge clk); #1;
    rnd_req  = 1'b0;
    key_req  = 1'b0;
    rnd_data = ~rnd_data;
    key_data = ~key_data;
    #1;
    done_at = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (!o_busy) busy_ok = 1'b0;
      if (is_key ? o_key_done : o_rnd_done) begin
        done_at = k;
        break;
      end
      @(posedge clk); #2;
    end
    check({name, " latency"}, 128'(done_at), 128'(lat + 1));
    check({name, " busy"}, 128'(busy_ok), 128'd1);
    if (is_key) begin
      check({name, " result"}, {96'b0, o_key_result}, exp);
      check({name, " rnd untouched"}, o_rnd_result, exp_rnd);
      exp_key = exp[31:0];
    end else begin
      check({name, " result"}, o_rnd_result, exp);
      check({name, " key untouched"}, {96'b0, o_key_result}, {96'b0, exp_key});
      exp_rnd = exp;
    end
    @(posedge clk); #2;
    check({name, " done cleared"}, 128'({o_rnd_done, o_key_done, o_busy}), 128'd0);
  endtask

  initial begin
    int kg[$];
    int rg[$];
    int kdone, rdone;
    bit flag;

    rst_n4 = 1'b0; rst_n1 = 1'b0; sel1 = 1'b0;
    rnd_req = 1'b0; key_req = 1'b0; rnd_data = '0; key_data = '0;
    exp_rnd = '0; exp_key = '0;

    vecs[0] = '{1'b1, {96'b0, 32'h00010253}, {96'b0, 32'h637C77ED}};
    vecs[1] = '{1'b0, VRnd, VRndExp};
    vecs[2] = '{1'b1, {96'b0, 32'h10203040}, {96'b0, 32'hCAB70409}};
    vecs[3] = '{1'b0, 128'h00010203_04050607_08090A0B_0C0D0E0F,
                128'h637C777B_F26B6FC5_3001672B_FED7AB76};
    vecs[4] = '{1'b1, {96'b0, 32'h50607080}, {96'b0, 32'h53D051CD}};
    vecs[5] = '{1'b0, 128'h90A0B0C0_D0E0F011_12131415_16171819,
                128'h60E0E7BA_70E18C82_C97DFA59_47F0ADD4};

    // Reset / idle
    apply_reset(1'b0);
    #1;
    check("reset rnd_result", o_rnd_result, 128'd0);
    check("reset key_result", {96'b0, o_key_result}, 128'd0);
    flag = 1'b0;
    repeat (20) begin
      @(posedge clk); #2;
      if (o_rnd_gnt || o_key_gnt || o_rnd_done || o_key_done || o_busy) flag = 1'b1;
    end
    check("idle outputs quiet", 128'(flag), 128'd0);

    // Table of single jobs, N=4
    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].is_key, vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Simultaneous requests after reset: key, rnd, key, rnd
    apply_reset(1'b0);
    @(posedge clk); #1;
    key_req = 1'b1; rnd_req = 1'b1; key_data = 32'h00010253; rnd_data = VRnd;
    #1;
    kdone = -1; rdone = -1; flag = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      if (o_key_gnt) kg.push_back(c);
      if (o_rnd_gnt) rg.push_back(c);
      if (o_key_gnt && o_rnd_gnt) flag = 1'b1;
      if (o_key_done && kdone < 0) kdone = c;
      if (o_rnd_done && rdone < 0) rdone = c;
      @(posedge clk); #2;
    end
    @(posedge clk); #1;
    key_req = 1'b0; rnd_req = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("tie two gnts", 128'(flag), 128'd0);
    check("tie key gnt0", 128'(kg.size() > 0 ? kg[0] : -1), 128'(0));
    check("tie key done", 128'(kdone), 128'(2));
    check("tie rnd gnt0", 128'(rg.size() > 0 ? rg[0] : -1), 128'(3));
    check("tie rnd done", 128'(rdone), 128'(8));
    check("tie key gnt1", 128'(kg.size() > 1 ? kg[1] : -1), 128'(9));
    check("tie rnd gnt1", 128'(rg.size() > 1 ? rg[1] : -1), 128'(12));
    check("tie key result", {96'b0, o_key_result}, 128'h637C77ED);
    check("tie rnd result", o_rnd_result, VRndExp);
    exp_key = 32'h637C77ED;
    exp_rnd = VRndExp;

    // Cancelled rnd request while a key job runs
    @(posedge clk); #1;
    key_req = 1'b1; key_data = 32'h10203040;
    #1;
    check("cancel key gnt", 128'(o_key_gnt), 128'd1);
    @(posedge clk); #1;
    key_req = 1'b0; rnd_req = 1'b1; rnd_data = '1;
    #1;
    check("cancel rnd gnt busy", 128'({o_rnd_gnt, o_busy}), 128'b01);
    @(posedge clk); #1;
    rnd_req = 1'b0;
    #1;
    check("cancel key done", 128'(o_key_done), 128'd1);
    check("cancel key result", {96'b0, o_key_result}, 128'hCAB70409);
    flag = 1'b0;
    repeat (15) begin
      if (o_rnd_gnt || o_rnd_done) flag = 1'b1;
      @(posedge clk); #2;
    end
    check("cancel no rnd activity", 128'(flag), 128'd0);
    check("cancel rnd result kept", o_rnd_result, exp_rnd);
    exp_key = 32'hCAB70409;

    // Reset in the middle of a rnd job
    apply_reset(1'b0);
    @(posedge clk); #1;
    rnd_req = 1'b1; rnd_data = VRnd;
    #1;
    check("midrst gnt", 128'(o_rnd_gnt), 128'd1);
    @(posedge clk);
    @(posedge clk); #1;
    check("midrst busy before", 128'(o_busy), 128'd1);
    rst_n4 = 1'b0;
    #1;
    check("midrst outputs low", 128'({o_busy, o_rnd_gnt, o_rnd_done}), 128'd0);
    check("midrst rnd_result", o_rnd_result, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rnd_req = 1'b0; rst_n4 = 1'b1;
    flag = 1'b0;
    repeat (20) begin
      @(posedge clk); #2;
      if (o_rnd_done || o_busy) flag = 1'b1;
    end
    check("midrst no done", 128'(flag), 128'd0);
    run_job(1'b0, VRnd, VRndExp, "midrst fresh");

    // N=1 instance
    apply_reset(1'b1);
    run_job(1'b0, VRnd, VRndExp, "n1 rnd");
    run_job(1'b1, {96'b0, 32'h00010253}, {96'b0, 32'h637C77ED}, "n1 key");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
